// File: rtl/ctrl_eoc_pkg.sv
// ctrl_eoc_pkg: offsets, response codes, FSM/select enums and helpers
// for the EOC register block. CTRL_EOC_CYCLE_COUNTER_EN maps CYCLES.
package ctrl_eoc_pkg;

  localparam logic [4:0] EXIT_OFF    = 5'h00;
  localparam logic [4:0] SCRATCH_OFF = 5'h08;
  localparam logic [4:0] CYCLES_OFF  = 5'h10;
  localparam logic [4:0] STATUS_OFF  = 5'h18;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    SEL_EXIT,
    SEL_SCRATCH,
    SEL_CYCLES,
    SEL_STATUS,
    SEL_NONE
  } reg_sel_e;

  typedef enum logic [2:0] {
    WR_IDLE,
    WR_AW_HELD,
    WR_W_HELD,
    WR_COMMIT,
    WR_RESP
  } wr_st_e;

  typedef enum logic {
    RD_IDLE,
    RD_RESP
  } rd_st_e;

  function automatic logic [63:0] apply_strb(
    input logic [63:0] old_v,
    input logic [63:0] new_v,
    input logic [7:0]  strb
  );
    logic [63:0] res;
    res = old_v;
    for (int i = 0; i < 8; i++) begin
      if (strb[i]) res[i*8 +: 8] = new_v[i*8 +: 8];
    end
    return res;
  endfunction

  function automatic reg_sel_e decode(
    input logic       hit,
    input logic [1:0] idx
  );
    reg_sel_e sel;
    sel = SEL_NONE;
    if (hit) begin
      unique case (idx)
        EXIT_OFF[4:3]:    sel = SEL_EXIT;
        SCRATCH_OFF[4:3]: sel = SEL_SCRATCH;
`ifdef CTRL_EOC_CYCLE_COUNTER_EN
        CYCLES_OFF[4:3]:  sel = SEL_CYCLES;
`endif
        STATUS_OFF[4:3]:  sel = SEL_STATUS;
        default:          sel = SEL_NONE;
      endcase
    end
    return sel;
  endfunction

endpackage

// File: rtl/ctrl_eoc_wr_join.sv
// ctrl_eoc_wr_join: holds AW and W independently, emits one commit pulse
// (o_commit + addr/data/strb) and owns b_valid until i_b_ready.
module ctrl_eoc_wr_join
  import ctrl_eoc_pkg::*;
#(
  parameter int unsigned AW = 64
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_live,
  input  logic [AW-1:0] i_aw_addr,
  input  logic          i_aw_valid,
  output logic          o_aw_ready,
  input  logic [63:0]   i_w_data,
  input  logic [7:0]    i_w_strb,
  input  logic          i_w_valid,
  output logic          o_w_ready,
  input  logic          i_b_ready,
  output logic          o_b_valid,
  output logic          o_commit,
  output logic [AW-1:0] o_addr,
  output logic [63:0]   o_data,
  output logic [7:0]    o_strb
);

  wr_st_e r_st;
  wr_st_e w_st_nxt;
  logic   w_aw_hs;
  logic   w_w_hs;

  assign o_aw_ready = i_live &&
    (r_st == WR_IDLE || r_st == WR_W_HELD);
  assign o_w_ready  = i_live &&
    (r_st == WR_IDLE || r_st == WR_AW_HELD);
  assign w_aw_hs    = i_aw_valid && o_aw_ready;
  assign w_w_hs     = i_w_valid && o_w_ready;
  assign o_commit   = (r_st == WR_COMMIT);
  assign o_b_valid  = (r_st == WR_RESP);

  always_comb begin
    w_st_nxt = r_st;
    unique case (r_st)
      WR_IDLE: begin
        if (w_aw_hs && w_w_hs) w_st_nxt = WR_COMMIT;
        else if (w_aw_hs)      w_st_nxt = WR_AW_HELD;
        else if (w_w_hs)       w_st_nxt = WR_W_HELD;
      end
      WR_AW_HELD: if (w_w_hs)  w_st_nxt = WR_COMMIT;
      WR_W_HELD:  if (w_aw_hs) w_st_nxt = WR_COMMIT;
      WR_COMMIT:               w_st_nxt = WR_RESP;
      WR_RESP:  if (i_b_ready) w_st_nxt = WR_IDLE;
      default:                 w_st_nxt = WR_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_st   <= WR_IDLE;
      o_addr <= '0;
      o_data <= '0;
      o_strb <= '0;
    end else begin
      r_st <= w_st_nxt;
      if (w_aw_hs) o_addr <= i_aw_addr;
      if (w_w_hs) begin
        o_data <= i_w_data;
        o_strb <= i_w_strb;
      end
    end
  end

endmodule

// File: rtl/ctrl_eoc_regs.sv
// ctrl_eoc_regs: AXI4-Lite EOC registers; exit_o = {code[62:0], done}.
// Ports: clk_i/rst_ni, AW/W/B/AR/R channels, exit_o. Macro: CTRL_EOC_CYCLE_COUNTER_EN.
module ctrl_eoc_regs
  import ctrl_eoc_pkg::*;
#(
  parameter int unsigned AxiAddrWidth = 64,
  parameter int unsigned AxiDataWidth = 64,
  parameter logic [63:0] BaseAddr     = 64'h0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [AxiAddrWidth-1:0] aw_addr_i,
  input  logic                    aw_valid_i,
  output logic                    aw_ready_o,
  input  logic [AxiDataWidth-1:0] w_data_i,
  input  logic [7:0]              w_strb_i,
  input  logic                    w_valid_i,
  output logic                    w_ready_o,
  output logic [1:0]              b_resp_o,
  output logic                    b_valid_o,
  input  logic                    b_ready_i,
  input  logic [AxiAddrWidth-1:0] ar_addr_i,
  input  logic                    ar_valid_i,
  output logic                    ar_ready_o,
  output logic [AxiDataWidth-1:0] r_data_o,
  output logic [1:0]              r_resp_o,
  output logic                    r_valid_o,
  input  logic                    r_ready_i,
  output logic [63:0]             exit_o
);

  if (AxiDataWidth != 64) begin : g_bad_dw
    $error("ctrl_eoc_regs: AxiDataWidth must be 64");
  end

  logic                    r_live;
  logic                    w_commit;
  logic [AxiAddrWidth-1:0] w_wr_addr;
  logic [63:0]             w_wr_data;
  logic [7:0]              w_wr_strb;
  logic [63:0]             r_exit;
  logic [63:0]             r_scratch;
  logic [1:0]              r_bresp;
  logic [63:0]             w_exit_nxt;
  logic [63:0]             w_scr_nxt;
  logic [1:0]              w_bresp;
  logic [63:0]             w_cycles;
  logic [63:0]             w_rdata;
  logic [1:0]              w_rresp;
  logic                    w_locked;
  logic                    w_ar_hs;
  reg_sel_e                w_wr_sel;
  reg_sel_e                w_rd_sel;
  rd_st_e                  r_rd_st;
  rd_st_e                  w_rd_nxt;
  logic                    w_unused_lsb;

  // Holds every ready low until the first edge after reset release.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_live <= 1'b0;
    else         r_live <= 1'b1;
  end

  ctrl_eoc_wr_join #(
    .AW (AxiAddrWidth)
  ) u_wr_join (
    .i_clk      (clk_i),
    .i_rst_n    (rst_ni),
    .i_live     (r_live),
    .i_aw_addr  (aw_addr_i),
    .i_aw_valid (aw_valid_i),
    .o_aw_ready (aw_ready_o),
    .i_w_data   (w_data_i),
    .i_w_strb   (w_strb_i),
    .i_w_valid  (w_valid_i),
    .o_w_ready  (w_ready_o),
    .i_b_ready  (b_ready_i),
    .o_b_valid  (b_valid_o),
    .o_commit   (w_commit),
    .o_addr     (w_wr_addr),
    .o_data     (w_wr_data),
    .o_strb     (w_wr_strb)
  );

  assign w_unused_lsb = ^{w_wr_addr[2:0], ar_addr_i[2:0]};
  assign w_locked     = r_exit[0];

  assign w_wr_sel = decode(
    w_wr_addr[AxiAddrWidth-1:5] == BaseAddr[AxiAddrWidth-1:5],
    w_wr_addr[4:3]);
  assign w_rd_sel = decode(
    ar_addr_i[AxiAddrWidth-1:5] == BaseAddr[AxiAddrWidth-1:5],
    ar_addr_i[4:3]);

  always_comb begin
    w_exit_nxt = r_exit;
    w_scr_nxt  = r_scratch;
    w_bresp    = RESP_SLVERR;
    if (w_commit) begin
      unique case (w_wr_sel)
        SEL_EXIT: begin
          w_bresp = RESP_OKAY;
          if (!w_locked)
            w_exit_nxt = apply_strb(r_exit, w_wr_data, w_wr_strb);
        end
        SEL_SCRATCH: begin
          w_bresp   = RESP_OKAY;
          w_scr_nxt = apply_strb(r_scratch, w_wr_data, w_wr_strb);
        end
        default: w_bresp = RESP_SLVERR;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_exit    <= '0;
      r_scratch <= '0;
      r_bresp   <= RESP_OKAY;
    end else begin
      r_exit    <= w_exit_nxt;
      r_scratch <= w_scr_nxt;
      if (w_commit) r_bresp <= w_bresp;
    end
  end

  assign exit_o   = r_exit;
  assign b_resp_o = r_bresp;

`ifdef CTRL_EOC_CYCLE_COUNTER_EN
  logic [63:0] r_cycles;

  // Stops on the same edge that sets the lock bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)             r_cycles <= '0;
    else if (!w_exit_nxt[0]) r_cycles <= r_cycles + 64'd1;
  end

  assign w_cycles = r_cycles;
`else
  assign w_cycles = '0;
`endif

  always_comb begin
    w_rdata = '0;
    w_rresp = RESP_SLVERR;
    unique case (w_rd_sel)
      SEL_EXIT: begin
        w_rdata = r_exit;
        w_rresp = RESP_OKAY;
      end
      SEL_SCRATCH: begin
        w_rdata = r_scratch;
        w_rresp = RESP_OKAY;
      end
      SEL_CYCLES: begin
        w_rdata = w_cycles;
        w_rresp = RESP_OKAY;
      end
      SEL_STATUS: begin
        w_rdata = {63'd0, w_locked};
        w_rresp = RESP_OKAY;
      end
      default: w_rresp = RESP_SLVERR;
    endcase
  end

  assign ar_ready_o = r_live && (r_rd_st == RD_IDLE);
  assign r_valid_o  = (r_rd_st == RD_RESP);
  assign w_ar_hs    = ar_valid_i && ar_ready_o;

  always_comb begin
    w_rd_nxt = r_rd_st;
    unique case (r_rd_st)
      RD_IDLE: if (w_ar_hs)   w_rd_nxt = RD_RESP;
      RD_RESP: if (r_ready_i) w_rd_nxt = RD_IDLE;
      default:                w_rd_nxt = RD_IDLE;
    endcase
  end

  // Sampled before this edge's commit lands, so a same-edge write is unseen.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_st  <= RD_IDLE;
      r_data_o <= '0;
      r_resp_o <= RESP_OKAY;
    end else begin
      r_rd_st <= w_rd_nxt;
      if (w_ar_hs) begin
        r_data_o <= w_rdata;
        r_resp_o <= w_rresp;
      end
    end
  end

endmodule

// File: tb/tb_ctrl_eoc_regs.sv
// tb_ctrl_eoc_regs: randomized scoreboard bench for ctrl_eoc_regs.
// Follows CTRL_EOC_CYCLE_COUNTER_EN for the CYCLES expectations.
module tb_ctrl_eoc_regs;

  localparam logic [63:0] BASE = 64'h0000_0000_4000_0000;
  localparam logic [1:0]  OKAY = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;

  typedef struct packed {
    logic [63:0] d;
    logic [1:0]  resp;
    logic        chk;
  } rexp_t;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic [63:0] aw_addr_i = '0;
  logic        aw_valid_i = 1'b0;
  logic        aw_ready_o;
  logic [63:0] w_data_i = '0;
  logic [7:0]  w_strb_i = '0;
  logic        w_valid_i = 1'b0;
  logic        w_ready_o;
  logic [1:0]  b_resp_o;
  logic        b_valid_o;
  logic        b_ready_i = 1'b0;
  logic [63:0] ar_addr_i = '0;
  logic        ar_valid_i = 1'b0;
  logic        ar_ready_o;
  logic [63:0] r_data_o;
  logic [1:0]  r_resp_o;
  logic        r_valid_o;
  logic        r_ready_i = 1'b0;
  logic [63:0] exit_o;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  logic [1:0] bq[$];
  rexp_t      rq[$];

  logic [63:0] m_exit = '0;
  logic [63:0] m_scr = '0;

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  ctrl_eoc_regs #(
    .AxiAddrWidth (64),
    .AxiDataWidth (64),
    .BaseAddr     (BASE)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .aw_addr_i  (aw_addr_i),
    .aw_valid_i (aw_valid_i),
    .aw_ready_o (aw_ready_o),
    .w_data_i   (w_data_i),
    .w_strb_i   (w_strb_i),
    .w_valid_i  (w_valid_i),
    .w_ready_o  (w_ready_o),
    .b_resp_o   (b_resp_o),
    .b_valid_o  (b_valid_o),
    .b_ready_i  (b_ready_i),
    .ar_addr_i  (ar_addr_i),
    .ar_valid_i (ar_valid_i),
    .ar_ready_o (ar_ready_o),
    .r_data_o   (r_data_o),
    .r_resp_o   (r_resp_o),
    .r_valid_o  (r_valid_o),
    .r_ready_i  (r_ready_i),
    .exit_o     (exit_o)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic fail_to(input string nm);
    n_chk++;
    n_err++;
    $display("FAIL %s: no handshake within bound, want one", nm);
  endtask

  // Register-map model: bytes merge under strobes, EXIT freezes once done.
  function automatic logic [1:0] m_write(input logic [63:0] a,
      input logic [63:0] d, input logic [7:0] s);
    if (a[63:5] != BASE[63:5]) return SLVERR;
    if (a[4:3] == 2'd0) begin
      if (m_exit[0] == 1'b0)
        for (int i = 0; i < 8; i++)
          if (s[i]) m_exit[i*8 +: 8] = d[i*8 +: 8];
      return OKAY;
    end
    if (a[4:3] == 2'd1) begin
      for (int i = 0; i < 8; i++)
        if (s[i]) m_scr[i*8 +: 8] = d[i*8 +: 8];
      return OKAY;
    end
    return SLVERR;
  endfunction

  function automatic rexp_t m_read(input logic [63:0] a);
    rexp_t e;
    e = '{d: 64'd0, resp: SLVERR, chk: 1'b1};
    if (a[63:5] == BASE[63:5]) begin
      case (a[4:3])
        2'd0: e = '{d: m_exit, resp: OKAY, chk: 1'b1};
        2'd1: e = '{d: m_scr, resp: OKAY, chk: 1'b1};
`ifdef CTRL_EOC_CYCLE_COUNTER_EN
        2'd2: e = '{d: 64'd0, resp: OKAY, chk: 1'b0};
`endif
        2'd3: e = '{d: {63'd0, m_exit[0]}, resp: OKAY, chk: 1'b1};
        default: e = '{d: 64'd0, resp: SLVERR, chk: 1'b1};
      endcase
    end
    return e;
  endfunction

  // Monitor: pops expectations on each B/R handshake, checks R stability.
  logic        prev_rv = 1'b0;
  logic        prev_rdy = 1'b0;
  logic [63:0] prev_d = '0;

  always @(negedge clk) begin
    if (rst_ni) begin
      if (b_valid_o && b_ready_i) begin
        if (bq.size() == 0) begin
          chk("b_unexpected", 64'd1, 64'd0);
        end else begin
          chk("b_resp", {62'd0, b_resp_o}, {62'd0, bq.pop_front()});
        end
      end
      if (r_valid_o && r_ready_i) begin
        if (rq.size() == 0) begin
          chk("r_unexpected", 64'd1, 64'd0);
        end else begin
          rexp_t e;
          e = rq.pop_front();
          chk("r_resp", {62'd0, r_resp_o}, {62'd0, e.resp});
          if (e.chk) chk("r_data", r_data_o, e.d);
        end
      end
      if (prev_rv && !prev_rdy) begin
        chk("r_hold_valid", {63'd0, r_valid_o}, 64'd1);
        chk("r_hold_data", r_data_o, prev_d);
      end
      prev_rv  = r_valid_o;
      prev_rdy = r_ready_i;
      prev_d   = r_data_o;
    end else begin
      prev_rv = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_aw(input logic [63:0] a, input int del);
    bit hs;
    int t;
    hs = 0;
    t = 0;
    repeat (del) tick();
    aw_addr_i  = a;
    aw_valid_i = 1'b1;
    while (!hs && t < 50) begin
      @(negedge clk);
      hs = aw_ready_o;
      tick();
      t++;
    end
    aw_valid_i = 1'b0;
    if (!hs) fail_to("aw_handshake");
  endtask

  task automatic send_w(input logic [63:0] d, input logic [7:0] s,
                        input int del);
    bit hs;
    int t;
    hs = 0;
    t = 0;
    repeat (del) tick();
    w_data_i  = d;
    w_strb_i  = s;
    w_valid_i = 1'b1;
    while (!hs && t < 50) begin
      @(negedge clk);
      hs = w_ready_o;
      tick();
      t++;
    end
    w_valid_i = 1'b0;
    if (!hs) fail_to("w_handshake");
  endtask

  task automatic b_accept();
    bit seen;
    int t;
    seen = 0;
    t = 0;
    while (!seen && t < 50) begin
      @(negedge clk);
      seen = b_valid_o;
      t++;
    end
    if (!seen) begin
      fail_to("b_valid");
      return;
    end
    tick();
    repeat ($urandom_range(0, 2)) tick();
    b_ready_i = 1'b1;
    tick();
    b_ready_i = 1'b0;
  endtask

  // lead > 0: W goes first by lead cycles; lead < 0: AW goes first.
  task automatic wr(input logic [63:0] a, input logic [63:0] d,
                    input logic [7:0] s, input int lead);
    bq.push_back(m_write(a, d, s));
    fork
      send_aw(a, lead > 0 ? lead : 0);
      send_w(d, s, lead < 0 ? -lead : 0);
    join
    b_accept();
  endtask

  task automatic rd(input logic [63:0] a, input int stall,
                    output logic [63:0] d);
    bit hs;
    int t;
    hs = 0;
    t = 0;
    d = '0;
    rq.push_back(m_read(a));
    ar_addr_i  = a;
    ar_valid_i = 1'b1;
    while (!hs && t < 50) begin
      @(negedge clk);
      hs = ar_ready_o;
      tick();
      t++;
    end
    ar_valid_i = 1'b0;
    if (!hs) begin
      fail_to("ar_handshake");
      return;
    end
    hs = 0;
    t = 0;
    while (!hs && t < 50) begin
      @(negedge clk);
      hs = r_valid_o;
      t++;
    end
    if (!hs) begin
      fail_to("r_valid");
      return;
    end
    d = r_data_o;
    tick();
    repeat (stall) tick();
    r_ready_i = 1'b1;
    tick();
    r_ready_i = 1'b0;
  endtask

  task automatic reset_dut();
    rst_ni     = 1'b0;
    aw_valid_i = 1'b0;
    w_valid_i  = 1'b0;
    ar_valid_i = 1'b0;
    b_ready_i  = 1'b0;
    r_ready_i  = 1'b0;
    #2;
    chk("rst_aw_ready", {63'd0, aw_ready_o}, 64'd0);
    chk("rst_w_ready", {63'd0, w_ready_o}, 64'd0);
    chk("rst_ar_ready", {63'd0, ar_ready_o}, 64'd0);
    chk("rst_b_valid", {63'd0, b_valid_o}, 64'd0);
    chk("rst_r_valid", {63'd0, r_valid_o}, 64'd0);
    chk("rst_exit", exit_o, 64'd0);
    chk("rst_resps", {60'd0, b_resp_o, r_resp_o}, 64'd0);
    chk("rst_r_data", r_data_o, 64'd0);
    bq.delete();
    rq.delete();
    m_exit = '0;
    m_scr  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] d;
    logic [63:0] d2;
    logic [63:0] a;
    int          k;

    reset_dut();

    // T1: reset with AW held and an R response pending.
    wr(BASE, 64'h4, 8'hFF, 0);
    chk("t1_exit_pre", exit_o, m_exit);
    aw_addr_i  = BASE + 64'h8;
    aw_valid_i = 1'b1;
    ar_addr_i  = BASE;
    ar_valid_i = 1'b1;
    tick();
    tick();
    reset_dut();
    rd(BASE, 0, d);

    // T2: lock with AW+W together, exact B latency, later write ignored.
    bq.push_back(m_write(BASE, 64'h1, 8'hFF));
    aw_addr_i  = BASE;
    aw_valid_i = 1'b1;
    w_data_i   = 64'h1;
    w_strb_i   = 8'hFF;
    w_valid_i  = 1'b1;
    tick();
    aw_valid_i = 1'b0;
    w_valid_i  = 1'b0;
    chk("t2_b_edge1", {63'd0, b_valid_o}, 64'd0);
    tick();
    chk("t2_b_edge2", {63'd0, b_valid_o}, 64'd1);
    chk("t2_exit", exit_o, 64'h1);
    b_accept();
    wr(BASE, 64'h7, 8'hFF, 0);
    chk("t2_exit_locked", exit_o, 64'h1);
    rd(BASE + 64'h18, 1, d);

    // T3: W three cycles ahead of AW, fail code 21.
    reset_dut();
    bq.push_back(m_write(BASE, 64'h2B, 8'hFF));
    fork
      send_w(64'h2B, 8'hFF, 0);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("t3_aw_ready", {63'd0, aw_ready_o}, 64'd1);
        end
        tick();
        send_aw(BASE, 0);
      end
    join
    b_accept();
    chk("t3_exit", exit_o, 64'h2B);
    chk("t3_code", {1'b0, exit_o[63:1]}, 64'd21);

    // T4: partial strobe on SCRATCH, slow R consumer.
    reset_dut();
    wr(BASE + 64'h8, 64'hDEAD_BEEF_CAFE_F00D, 8'h0F,
       $urandom_range(0, 4) - 2);
    rd(BASE + 64'h8, 4, d);
    chk("t4_scratch", d, 64'h0000_0000_CAFE_F00D);

    // T5: outside the window.
    wr(BASE + 64'h40, 64'h1234, 8'hFF, 0);
    rd(BASE + 64'h40, 0, d);
    rd(BASE, 0, d);
    rd(BASE + 64'h8, 0, d);
    chk("t5_exit", exit_o, m_exit);

    // Randomized mix against the model.
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 5))
        0, 1, 2, 3: a = BASE + 64'(8 * $urandom_range(0, 3));
        4:          a = BASE + 64'h40 + 64'(8 * $urandom_range(0, 3));
        default:    a = {$urandom, $urandom};
      endcase
      a[2:0] = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) begin
        d = {$urandom, $urandom};
        d[0] = ($urandom_range(0, 7) == 0);
        wr(a, d, 8'($urandom_range(0, 255)), $urandom_range(0, 6) - 3);
        chk("rand_exit", exit_o, m_exit);
      end else begin
        rd(a, $urandom_range(0, 3), d);
      end
    end

    // T6: cycle counter freezes at lock.
    reset_dut();
    repeat ($urandom_range(5, 40)) tick();
`ifdef CTRL_EOC_CYCLE_COUNTER_EN
    k = cyc;
    wr(BASE, 64'h1, 8'hFF, 0);
    rd(BASE + 64'h10, 0, d);
    n_chk++;
    if (d < 64'(k) || d > 64'(k + 2)) begin
      n_err++;
      $display("FAIL t6_cycles: got %0d, want %0d..%0d", d, k, k + 2);
    end
    repeat (100) tick();
    rd(BASE + 64'h10, 2, d2);
    n_chk++;
    if (d2 < 64'(k) || d2 > 64'(k + 2)) begin
      n_err++;
      $display("FAIL t6_cycles_late: got %0d, want %0d..%0d",
               d2, k, k + 2);
    end
    chk("t6_cycles_frozen", d2, d);
`else
    k = cyc;
    wr(BASE, 64'h1, 8'hFF, 0);
    rd(BASE + 64'h10, 0, d);
    chk("t6_unmapped_data", d, 64'd0);
    chk("t6_exit", exit_o, 64'h1);
    n_chk++;
    if (k < 0) n_err++;
`endif

    repeat (3) tick();
    chk("end_b_queue", 64'(bq.size()), 64'd0);
    chk("end_r_queue", 64'(rq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
